disp_sseg_capture: RTL and testbench

Receive-side decoder for the multiplexed 4-digit, active-low 7-segment bus driven by disp_hex_mux (an[3:0], sseg[7:0]). It samples the scanned bus, rejects switching glitches and ghosting, and inverts the segment encoding back to 4-bit hex digits plus decimal points. It then publishes complete, coherent 4-digit frames. It is used for on-chip loopback self-test of display paths such as the stopwatch, and as a bench monitor.

---
 rtl/disp_sseg_capture.sv | 183 ++++++++++++++++++
 tb/tb_disp_sseg_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_sseg_capture.sv
// Receive-side decoder for a scanned 4-digit active-low 7-segment bus.
// Debounces each scan slot, maps glyphs back to hex and publishes whole frames.
module disp_sseg_capture #(
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned TIMEOUT_W  = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out,
    output logic [3:0] pattern_err,
    output logic       frame_tick,
    output logic       stale
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYC - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_e;

    state_e               state_q;
    logic [3:0]           an_s1_q, an_s2_q, an_p_q;
    logic [7:0]           sseg_s1_q, sseg_s2_q, sseg_p_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0][3:0]      shadow_hex_q, shadow_hex_d;
    logic [3:0]           shadow_dp_q, shadow_dp_d;
    logic [3:0]           shadow_err_q, shadow_err_d;
    logic [3:0]           seen_q, seen_d, seen_cap;
    logic [3:0][3:0]      hex_q;
    logic [3:0]           dp_q, err_q;
    logic                 tick_q;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 stale_q, stale_d;

    logic       an_valid;
    logic       same;
    logic       capture;
    logic       commit;
    logic [1:0] dig_idx;
    logic       glyph_hit;
    logic [3:0] glyph_val;

    // A sample is "same" only if the anode is a legal single digit and nothing moved.
    assign an_valid = $onehot(~an_s2_q);
    assign same     = an_valid && ({an_s2_q, sseg_s2_q} == {an_p_q, sseg_p_q});
    assign cnt_d    = !same ? '0 : ((cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1);
    assign capture  = (state_q == S_SETTLE) && same && (cnt_q == CNT_CAP);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dig_idx = 2'd0;
        case (~an_s2_q)
            4'b0010: dig_idx = 2'd1;
            4'b0100: dig_idx = 2'd2;
            4'b1000: dig_idx = 2'd3;
            default: dig_idx = 2'd0;
        endcase
    end

    always_comb begin
        glyph_hit = 1'b1;
        glyph_val = 4'h0;
        case (sseg_s2_q[6:0])
            7'b0000001: glyph_val = 4'h0;
            7'b1001111: glyph_val = 4'h1;
            7'b0010010: glyph_val = 4'h2;
            7'b0000110: glyph_val = 4'h3;
            7'b1001100: glyph_val = 4'h4;
            7'b0100100: glyph_val = 4'h5;
            7'b0100000: glyph_val = 4'h6;
            7'b0001111: glyph_val = 4'h7;
            7'b0000000: glyph_val = 4'h8;
            7'b0000100: glyph_val = 4'h9;
            7'b0001000: glyph_val = 4'hA;
            7'b1100000: glyph_val = 4'hB;
            7'b0110001: glyph_val = 4'hC;
            7'b1000010: glyph_val = 4'hD;
            7'b0110000: glyph_val = 4'hE;
            7'b0111000: glyph_val = 4'hF;
            default:    glyph_hit = 1'b0;
        endcase
    end

    always_comb begin
        shadow_hex_d = shadow_hex_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_err_d = shadow_err_q;
        seen_cap     = seen_q | ~an_s2_q;
        if (capture) begin
            shadow_dp_d[dig_idx]  = ~sseg_s2_q[7];
            shadow_err_d[dig_idx] = ~glyph_hit;
            if (glyph_hit) begin
                shadow_hex_d[dig_idx] = glyph_val;
            end
        end
    end

    // The commit uses the next-shadow values so the capture completing the frame is included.
    assign commit  = capture && (&seen_cap);
    assign seen_d  = commit ? 4'b0000 : (capture ? seen_cap : seen_q);
    assign wd_d    = commit ? '0 : ((&wd_q) ? wd_q : wd_q + 1'b1);
    assign stale_d = commit ? 1'b0 : ((&wd_d) ? 1'b1 : stale_q);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            an_s1_q      <= '0;
            an_s2_q      <= '0;
            an_p_q       <= '0;
            sseg_s1_q    <= '0;
            sseg_s2_q    <= '0;
            sseg_p_q     <= '0;
            cnt_q        <= '0;
            // NOTE: shadows are reset too; an illegal glyph keeps the old shadow digit,
            // so an unreset value could otherwise leak into the first frame.
            shadow_hex_q <= '0;
            shadow_dp_q  <= '0;
            shadow_err_q <= '0;
            seen_q       <= '0;
            hex_q        <= '0;
            dp_q         <= '0;
            err_q        <= '0;
            tick_q       <= 1'b0;
            wd_q         <= '0;
            stale_q      <= 1'b1;
        end else begin
            an_s1_q      <= an;
            an_s2_q      <= an_s1_q;
            an_p_q       <= an_s2_q;
            sseg_s1_q    <= sseg;
            sseg_s2_q    <= sseg_s1_q;
            sseg_p_q     <= sseg_s2_q;
            cnt_q        <= cnt_d;
            shadow_hex_q <= shadow_hex_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_err_q <= shadow_err_d;
            seen_q       <= seen_d;
            tick_q       <= commit;
            wd_q         <= wd_d;
            stale_q      <= stale_d;
            if (commit) begin
                hex_q <= shadow_hex_d;
                dp_q  <= shadow_dp_d;
                err_q <= shadow_err_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (an_valid) state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!an_valid)    state_q <= S_IDLE;
                    else if (capture) state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (!same) state_q <= an_valid ? S_SETTLE : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hex3        = hex_q[3];
    assign hex2        = hex_q[2];
    assign hex1        = hex_q[1];
    assign hex0        = hex_q[0];
    assign dp_out      = dp_q;
    assign pattern_err = err_q;
    assign frame_tick  = tick_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_disp_sseg_capture.sv
// Bench for disp_sseg_capture: directed scan scenarios plus random slots,
// compared every cycle against a run-length based frame model.
module tb_disp_sseg_capture;

    localparam int STABLE   = 16;
    localparam int TW       = 8;
    localparam int WD_LIMIT = (1 << TW) - 1;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] an = 4'hF;
    logic [7:0] sseg = 8'hFF;
    logic [3:0] hex3, hex2, hex1, hex0, dp_out, pattern_err;
    logic       frame_tick, stale;

    int tests = 0;
    int fails = 0;
    int dut_ticks = 0;

    disp_sseg_capture #(.STABLE_CYC(STABLE), .TIMEOUT_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .an(an), .sseg(sseg),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .dp_out(dp_out), .pattern_err(pattern_err),
        .frame_tick(frame_tick), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit decode(input logic [6:0] g, output logic [3:0] val);
        val = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == g) begin
                val = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Reference model: the bus reaches the decoder two edges late; a digit is taken
    // once per run of identical valid samples, when that run reaches STABLE cycles.
    logic [11:0] dly0 = '0, dly1 = '0, last_v = '0;
    int          run = 0;
    logic [3:0]  m_sh_hex [4] = '{default: 4'h0};
    logic [3:0]  m_sh_dp = '0, m_sh_err = '0, m_seen = '0;
    logic [3:0]  m_hex [4] = '{default: 4'h0};
    logic [3:0]  m_dp = '0, m_err = '0;
    logic        m_tick = 1'b0;
    int          since = 0;
    bit          committed = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        logic [11:0] v;
        logic [3:0]  val;
        int          d;
        if (!reset_n) begin
            dly0 = '0; dly1 = '0; last_v = '0; run = 0;
            m_sh_hex = '{default: 4'h0}; m_sh_dp = '0; m_sh_err = '0; m_seen = '0;
            m_hex = '{default: 4'h0}; m_dp = '0; m_err = '0; m_tick = 1'b0;
            since = 0; committed = 1'b0;
        end else begin
            v = dly1;
            dly1 = dly0;
            dly0 = {an, sseg};
            m_tick = 1'b0;
            if (since < 1000000) since++;
            if ($countones(v[11:8]) == 3) run = (v == last_v) ? run + 1 : 1;
            else                          run = 0;
            last_v = v;
            if (run == STABLE) begin
                d = 0;
                for (int i = 0; i < 4; i++) if (!v[8+i]) d = i;
                m_sh_dp[d] = ~v[7];
                if (decode(v[6:0], val)) begin
                    m_sh_hex[d] = val;
                    m_sh_err[d] = 1'b0;
                end else begin
                    m_sh_err[d] = 1'b1;
                end
                m_seen[d] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_hex = m_sh_hex; m_dp = m_sh_dp; m_err = m_sh_err;
                    m_seen = '0; m_tick = 1'b1; since = 0; committed = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("hex", {hex3, hex2, hex1, hex0}, {m_hex[3], m_hex[2], m_hex[1], m_hex[0]});
        check("dp_out", dp_out, m_dp);
        check("pattern_err", pattern_err, m_err);
        check("frame_tick", frame_tick, m_tick);
        check("stale", stale, (!committed || since >= WD_LIMIT));
        if (frame_tick === 1'b1) dut_ticks++;
    end

    function automatic logic [3:0] an_of(input int d);
        return ~(4'b0001 << d);
    endfunction

    // Inputs always change 1 time unit after a rising edge.
    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a;
        sseg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic slot(input int d, input int val, input bit dp, input int n);
        hold(an_of(d), {~dp, GLYPH[val]}, n);
    endtask

    task automatic frame(input int v3, input int v2, input int v1, input int v0,
                         input logic [3:0] dpm, input int n);
        slot(3, v3, dpm[3], n);
        slot(2, v2, dpm[2], n);
        slot(1, v1, dpm[1], n);
        slot(0, v0, dpm[0], n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int n;
        @(posedge clk);
        #1;
        // Reset held with blank anodes, then a long idle
        hold(4'hF, 8'hFF, 3);
        reset_n = 1'b1;
        hold(4'hF, 8'hFF, 50);
        check("idle_stale", stale, 1);
        check("idle_hex", {hex3, hex2, hex1, hex0, dp_out, pattern_err}, 0);
        check("idle_ticks", dut_ticks, 0);

        // Clean scan
        frame(0, 1, 2, 3, 4'b0100, 64);
        hold(4'hF, 8'hFF, 4);
        check("clean_ticks", dut_ticks, 1);
        check("clean_hex", {hex3, hex2, hex1, hex0}, 16'h0123);
        check("clean_dp", dp_out, 4'b0100);
        check("clean_err", pattern_err, 4'b0000);
        check("clean_stale", stale, 0);

        // Short slot and periodic 1-cycle glitches must not capture digit 0
        t0 = dut_ticks;
        slot(3, 4, 0, 64); slot(2, 5, 0, 64); slot(1, 6, 0, 64);
        slot(0, 7, 0, 10);
        slot(3, 4, 0, 64);
        for (int k = 0; k < 8; k++) begin
            hold(an_of(0), {1'b1, GLYPH[7]}, 7);
            hold(an_of(0), {1'b1, GLYPH[7]} ^ 8'h01, 1);
        end
        check("glitch_no_tick", dut_ticks, t0);
        slot(0, 7, 0, 64);
        check("glitch_recover_tick", dut_ticks, t0 + 1);
        check("glitch_hex", {hex3, hex2, hex1, hex0}, 16'h4567);

        // Illegal glyph on digit 1 keeps the previous hex1
        slot(3, 8, 0, 64); slot(2, 9, 0, 64);
        hold(an_of(1), 8'hFF, 64);
        slot(0, 10, 0, 64);
        check("illegal_err", pattern_err, 4'b0010);
        check("illegal_hex", {hex3, hex2, hex1, hex0}, 16'h896A);
        frame(11, 12, 13, 14, 4'b1001, 64);
        check("illegal_cleared", pattern_err, 4'b0000);
        check("illegal_next_hex", {hex3, hex2, hex1, hex0, dp_out}, 20'hBCDE9);

        // Multi-low anode is ignored
        t0 = dut_ticks;
        hold(4'b1100, {1'b1, GLYPH[5]}, 100);
        check("bad_an_no_tick", dut_ticks, t0);
        frame(15, 0, 1, 2, 4'b0000, 64);
        check("bad_an_resume", dut_ticks, t0 + 1);
        check("bad_an_hex", {hex3, hex2, hex1, hex0}, 16'hF012);

        // Watchdog: count edges from the frame tick to stale
        slot(3, 3, 0, 64); slot(2, 4, 0, 64); slot(1, 5, 0, 64);
        an = an_of(0);
        sseg = {1'b1, GLYPH[6]};
        n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wd_tick_seen", (n < 100), 1);
        an = 4'hF;
        sseg = 8'hFF;
        n = 0;
        while (stale !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wd_stale_cycles", n, WD_LIMIT);
        check("wd_hex_kept", {hex3, hex2, hex1, hex0}, 16'h3456);
        hold(4'hF, 8'hFF, 20);

        // Reset after two captures discards them
        slot(3, 7, 0, 64); slot(2, 8, 0, 64);
        reset_n = 1'b0;
        hold(4'hF, 8'hFF, 3);
        reset_n = 1'b1;
        check("rst_hex", {hex3, hex2, hex1, hex0, stale}, 17'h1);
        t0 = dut_ticks;
        slot(1, 9, 0, 64); slot(0, 10, 0, 64);
        check("rst_partial_no_tick", dut_ticks, t0);
        slot(3, 11, 0, 64); slot(2, 12, 1, 64);
        check("rst_fresh_tick", dut_ticks, t0 + 1);
        check("rst_fresh_hex", {hex3, hex2, hex1, hex0, dp_out}, 20'hBC9A4);

        // Random slots: lengths around the threshold, illegal glyphs, bad anodes, glitches
        for (int k = 0; k < 400; k++) begin
            logic [3:0] a;
            logic [7:0] s;
            int         len;
            len = $urandom_range(1, 48);
            if ($urandom_range(0, 9) == 0) a = 4'($urandom);
            else                           a = an_of($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) s = 8'($urandom);
            else                           s = {1'($urandom), GLYPH[$urandom_range(0, 15)]};
            if ($urandom_range(0, 9) == 0 && len > 4) begin
                hold(a, s, len / 2);
                hold(a, s ^ (8'h01 << $urandom_range(0, 7)), 1);
                hold(a, s, len - len / 2 - 1);
            end else begin
                hold(a, s, len);
            end
        end
        hold(4'hF, 8'hFF, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
